// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the ysyx_23060332 load/store unit: RV32 load/store
// func3 codes, byte-strobe base patterns, LSU FSM state encoding and the
// misaligned-access predicate used by the optional misalignment check
// (enabled by defining LSU_MISALIGN_CHECK_EN).
package ysyx_23060332_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;
    localparam logic [3:0] STRB_NONE = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Halfword accesses need a[0]==0, word accesses need a[1:0]==0.
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [2:0] func3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (is_load) begin
            case (func3)
                F3_H, F3_HU: mis = addr_lo[0];
                F3_W:        mis = (addr_lo != 2'b00);
                default:     mis = 1'b0;
            endcase
        end else begin
            case (func3)
                F3_H:    mis = addr_lo[0];
                F3_W:    mis = (addr_lo != 2'b00);
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Combinational byte-lane helper for the LSU.
// Ports:
//   func3     - RV32 load/store func3
//   addr_lo   - low two bits of the effective address
//   wdata     - raw store data (rs2)
//   rdata     - raw read word from the bus
//   wstrb     - store byte strobes (0 for unsupported func3)
//   wdata_rep - store data replicated across the lanes
//   rdata_ext - load result after lane shift and sign/zero extension
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        wstrb     = STRB_NONE;
        wdata_rep = wdata;
        case (func3)
            F3_B: begin
                wstrb     = STRB_B << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                wstrb     = STRB_H << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            F3_W:    wstrb = STRB_W;
            default: wstrb = STRB_NONE;
        endcase

        // Lanes above bit 31 shift out as zeros.
        shifted = rdata >> {addr_lo, 3'b000};
        case (func3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Multi-cycle load/store unit between EXU and WBU.
// Accepts one op per in_valid/in_ready handshake, issues at most one
// word-aligned bus request (mem_req_*), waits for mem_resp_valid, and
// presents one writeback record on out_valid/out_ready.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_*            - op from EXU (ren/wen/func3/addr/wdata/alu_result/rd/reg_wen)
//   mem_req_*       - bus request (valid/ready, wen, addr, wdata, wstrb)
//   mem_resp_*      - bus response (valid, rdata)
//   out_*           - writeback record (valid/ready, rd, wdata, reg_wen, err)
// Optional: define LSU_MISALIGN_CHECK_EN to turn misaligned halfword/word
// accesses into an error record without a bus request.
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic [2:0]        in_func3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_reg_wen,
    output logic              out_err
);

    lsu_state_e        state_q, state_d;
    logic              load_q, store_q, reg_wen_q, err_q;
    logic [2:0]        func3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, wb_q;
    logic [4:0]        rd_q;

    logic        accept, mem_op, mis_now;
    logic [3:0]  strb;
    logic [31:0] wdata_rep, rdata_ext;

    assign mem_op = in_ren || in_wen;
    assign accept = in_valid && in_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis_now = mem_op && is_misaligned(in_ren, in_func3, in_addr[1:0]);
`else
    assign mis_now = 1'b0;
`endif

    ysyx_23060332_lsu_align u_align (
        .func3     (func3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_resp_rdata),
        .wstrb     (strb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            reg_wen_q <= 1'b0;
            err_q     <= 1'b0;
            func3_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                load_q    <= in_ren;
                store_q   <= in_wen && !in_ren;
                reg_wen_q <= in_reg_wen;
                err_q     <= mis_now;
                func3_q   <= in_func3;
                addr_q    <= in_addr;
                wdata_q   <= in_wdata;
                rd_q      <= in_rd;
                // Pass-through result is final here; memory ops start at 0
                // and only loads overwrite it on the response.
                wb_q      <= mem_op ? '0 : in_alu_result;
            end
            if (state_q == S_WAIT && mem_resp_valid && load_q) begin
                wb_q <= rdata_ext;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        in_ready      = (state_q == S_IDLE) && !rst;
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wstrb = '0;
        out_valid     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = (mem_op && !mis_now) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = store_q;
                mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_req_wdata = wdata_rep;
                mem_req_wstrb = store_q ? strb : 4'b0000;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_rd      = rd_q;
    assign out_wdata   = wb_q;
    assign out_err     = err_q;
    assign out_reg_wen = reg_wen_q && (rd_q != 5'd0) && !store_q && !err_q;

endmodule
